// File: rtl/cpu_irq_ctrl.sv
// cpu_irq_ctrl: CPU-side interrupt controller for the fabric IRQ lines.
// Both the IRQ lines and the fabric-configured flag are asynchronous to CLK,
// so each one passes through a synchroniser before it is used.
// After that, a per-line mask and an edge/level mode are applied.
// Pending interrupts are latched, and the lowest pending index is presented
// to the CPU over a req/ack handshake.
//
// Optional feature: define CPU_IRQ_CTRL_COUNT_EN to build a saturating 16-bit
// counter of accepted acknowledges. Without it, irq_count is tied to zero.
module cpu_irq_ctrl #(
  parameter int NUM_IRQ     = 4,
  parameter int SYNC_STAGES = 2,
  localparam int ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NUM_IRQ-1:0] IRQ_top,
  input  logic               CONFIGURED_top,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic [NUM_IRQ-1:0] irq_edge_mode,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  output logic [15:0]        irq_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  // Synchroniser chains; index SYNC_STAGES-1 is the CLK-domain view.
  logic [NUM_IRQ-1:0]     r_irq_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] r_cfg_sync;

  logic [NUM_IRQ-1:0] r_prev;
  logic [NUM_IRQ-1:0] r_pend;
  state_t             r_state;
  logic               r_req;
  logic [ID_W-1:0]    r_id;

  logic [NUM_IRQ-1:0] w_s_irq;
  logic               w_s_cfg;
  logic               w_accept;
  logic [NUM_IRQ-1:0] w_clr;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_pend_edge;
  logic [NUM_IRQ-1:0] w_pend_level;
  logic [NUM_IRQ-1:0] w_pend_nxt;
  logic [ID_W-1:0]    w_low_id;

  assign w_s_irq = r_irq_sync[SYNC_STAGES-1];
  assign w_s_cfg = r_cfg_sync[SYNC_STAGES-1];

  // An acknowledge only counts while a request is actually outstanding.
  // If the fabric has gone unconfigured in the same cycle, that wins instead.
  assign w_accept = (r_state == ST_REQ) && irq_ack && w_s_cfg;

  // Multi-flop synchronisers for the asynchronous IRQ lines and configured flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_irq_sync[k] <= '0;
      end
      r_cfg_sync <= '0;
    end else begin
      r_irq_sync[0] <= IRQ_top;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_irq_sync[k] <= r_irq_sync[k-1];
      end
      r_cfg_sync <= {r_cfg_sync[SYNC_STAGES-2:0], CONFIGURED_top};
    end
  end

  // Edge history: the synchronised line value from the previous cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_prev <= '0;
    end else begin
      r_prev <= w_s_irq;
    end
  end

  // Build a one-hot clear for the line whose request was just accepted.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_clr[i] = w_accept && (r_id == ID_W'(i));
    end
  end

  // Next pending state.
  // Edge lines hold until acked, and a new edge beats a same-cycle clear.
  // Level lines simply follow the masked input.
  always_comb begin
    w_rise       = w_s_irq & ~r_prev & irq_mask;
    w_pend_edge  = (r_pend & ~w_clr) | w_rise;
    w_pend_level = w_s_irq & irq_mask;
    w_pend_nxt   = (irq_edge_mode & w_pend_edge) | (~irq_edge_mode & w_pend_level);
  end

  // Pending register; losing the fabric configuration drops everything.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_pend <= '0;
    end else if (!w_s_cfg) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

  // Fixed priority: the lowest set index wins.
  always_comb begin
    w_low_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_low_id = ID_W'(i);
      end
    end
  end

  // Request FSM.
  // REQ holds its ID until acked, even if the source goes away.
  // HOLD gives one cycle for the cleared pending state to settle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_id    <= '0;
    end else if (!w_s_cfg) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|r_pend) begin
            r_id    <= w_low_id;
            r_req   <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            r_req   <= 1'b0;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign irq_pending = r_pend;
  assign irq_req     = r_req;
  assign irq_id      = r_id;

`ifdef CPU_IRQ_CTRL_COUNT_EN
  logic [15:0] r_count;

  // Saturating count of accepted acks; only RST clears it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count <= 16'h0000;
    end else if (w_accept && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign irq_count = r_count;
`else
  assign irq_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cpu_irq_ctrl.sv
// Directed bench for cpu_irq_ctrl (NUM_IRQ=4, SYNC_STAGES=2).
// Expected request IDs are queued when a line is driven, then popped and
// compared when irq_req appears.
// Count expectations follow CPU_IRQ_CTRL_COUNT_EN.
module tb_cpu_irq_ctrl;

`ifdef CPU_IRQ_CTRL_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic       CLK;
  logic       RST;
  logic [3:0] IRQ_top;
  logic       CONFIGURED_top;
  logic [3:0] irq_mask;
  logic [3:0] irq_edge_mode;
  logic [3:0] irq_pending;
  logic       irq_req;
  logic [1:0] irq_id;
  logic       irq_ack;
  logic [15:0] irq_count;

  int          total = 0;
  int          bad   = 0;
  int          exp_q[$];
  logic [15:0] exp_count = 16'h0000;

  cpu_irq_ctrl #(.NUM_IRQ(4), .SYNC_STAGES(2)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .IRQ_top        (IRQ_top),
    .CONFIGURED_top (CONFIGURED_top),
    .irq_mask       (irq_mask),
    .irq_edge_mode  (irq_edge_mode),
    .irq_pending    (irq_pending),
    .irq_req        (irq_req),
    .irq_id         (irq_id),
    .irq_ack        (irq_ack),
    .irq_count      (irq_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_count(input string tag);
    check(tag, 32'(irq_count), COUNT_EN ? 32'(exp_count) : 32'h0);
  endtask

  task automatic wait_req(input string tag);
    int n;
    int e;
    n = 0;
    while (irq_req !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    total++;
    assert (irq_req === 1'b1) else begin
      bad++;
      $error("FAIL %s_req_timeout: observed=%0b expected=1", tag, irq_req);
    end
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_no_expectation: observed=%0d expected=queued id", tag, irq_id);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_id"}, 32'(irq_id), 32'(e));
    end
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
  endtask

  task automatic pulse(input logic [3:0] lines);
    IRQ_top = lines;
    step(1);
    IRQ_top = 4'h0;
  endtask

  initial begin
    RST = 1'b1;
    IRQ_top = 4'hF;
    CONFIGURED_top = 1'b0;
    irq_mask = 4'h0;
    irq_edge_mode = 4'h0;
    irq_ack = 1'b0;
    step(3);

    // 1. reset values, then unconfigured fabric keeps everything quiet
    check("rst_req", 32'(irq_req), 32'h0);
    check("rst_pend", 32'(irq_pending), 32'h0);
    check("rst_count", 32'(irq_count), 32'h0);
    RST = 1'b0;
    irq_mask = 4'hF;
    irq_edge_mode = 4'hF;
    step(6);
    check("uncfg_req", 32'(irq_req), 32'h0);
    check("uncfg_pend", 32'(irq_pending), 32'h0);
    IRQ_top = 4'h0;
    step(4);

    // 2. single edge on line 2, exact latency
    CONFIGURED_top = 1'b1;
    step(4);
    exp_q.push_back(2);
    pulse(4'b0100);
    step(2);
    check("lat_req_early", 32'(irq_req), 32'h0);
    check("lat_pend", 32'(irq_pending), 32'h4);
    step(1);
    check("lat_req_edge4", 32'(irq_req), 32'h1);
    wait_req("t2");
    do_ack();
    check("t2_pend_clr", 32'(irq_pending), 32'h0);
    check("t2_req_drop", 32'(irq_req), 32'h0);
    step(3);
    check("t2_no_rereq", 32'(irq_req), 32'h0);
    check_count("t2_count");

    // 3. simultaneous edges on lines 3 and 1, priority and back-to-back spacing
    exp_q.push_back(1);
    exp_q.push_back(3);
    pulse(4'b1010);
    wait_req("t3a");
    check("t3_pend_both", 32'(irq_pending), 32'hA);
    do_ack();
    check("t3_pend_after_ack", 32'(irq_pending), 32'h8);
    check("t3_gap0", 32'(irq_req), 32'h0);
    step(1);
    check("t3_gap1", 32'(irq_req), 32'h0);
    step(1);
    check("t3_rereq", 32'(irq_req), 32'h1);
    wait_req("t3b");
    do_ack();
    check_count("t3_count");

    // 4. level mode on line 0
    irq_edge_mode = 4'b1110;
    IRQ_top = 4'b0001;
    exp_q.push_back(0);
    wait_req("t4a");
    do_ack();
    check("t4_pend_kept", 32'(irq_pending), 32'h1);
    check("t4_gap0", 32'(irq_req), 32'h0);
    step(1);
    check("t4_gap1", 32'(irq_req), 32'h0);
    exp_q.push_back(0);
    step(1);
    check("t4_rereq", 32'(irq_req), 32'h1);
    wait_req("t4b");
    IRQ_top = 4'h0;
    step(2);
    check("t4_pend_sync", 32'(irq_pending), 32'h1);
    step(1);
    check("t4_pend_drop", 32'(irq_pending), 32'h0);
    check("t4_req_held", 32'(irq_req), 32'h1);
    do_ack();
    step(4);
    check("t4_no_rereq", 32'(irq_req), 32'h0);
    check_count("t4_count");
    irq_edge_mode = 4'hF;

    // 5. new edge on line 1 in the same cycle its request is acked
    exp_q.push_back(1);
    pulse(4'b0010);
    wait_req("t5a");
    IRQ_top = 4'b0010;
    step(2);
    do_ack();
    check("t5_set_wins", 32'(irq_pending), 32'h2);
    exp_q.push_back(1);
    step(2);
    check("t5_rereq", 32'(irq_req), 32'h1);
    wait_req("t5b");
    do_ack();
    check("t5_pend_clr", 32'(irq_pending), 32'h0);
    step(3);
    check("t5_quiet", 32'(irq_req), 32'h0);
    IRQ_top = 4'h0;
    step(3);
    check_count("t5_count");

    // masking blocks new edges but leaves an existing pending bit alone
    irq_mask = 4'b1011;
    pulse(4'b0100);
    step(6);
    check("mask_block_pend", 32'(irq_pending), 32'h0);
    check("mask_block_req", 32'(irq_req), 32'h0);
    irq_mask = 4'hF;
    exp_q.push_back(2);
    pulse(4'b0100);
    wait_req("mask");
    irq_mask = 4'b1011;
    step(2);
    check("mask_keep_pend", 32'(irq_pending), 32'h4);
    check("mask_keep_req", 32'(irq_req), 32'h1);
    do_ack();
    check("mask_ack_clr", 32'(irq_pending), 32'h0);
    irq_mask = 4'hF;
    step(2);

    // 6. configured flag falls while a request is outstanding
    exp_q.push_back(3);
    pulse(4'b1000);
    wait_req("t6");
    CONFIGURED_top = 1'b0;
    step(2);
    check("t6_req_before", 32'(irq_req), 32'h1);
    step(1);
    check("t6_req_drop", 32'(irq_req), 32'h0);
    check("t6_pend_drop", 32'(irq_pending), 32'h0);
    CONFIGURED_top = 1'b1;
    step(4);
    check("t6_after_req", 32'(irq_req), 32'h0);
    check("t6_after_pend", 32'(irq_pending), 32'h0);
    check_count("t6_count");

    // ack while idle is ignored
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    step(2);
    check("idle_ack_req", 32'(irq_req), 32'h0);
    check_count("idle_ack_count");

`ifdef CPU_IRQ_CTRL_COUNT_EN
    // saturation of the accepted-ack counter
    force dut.r_count = 16'hFFFE;
    #2;
    release dut.r_count;
    exp_count = 16'hFFFE;
    repeat (2) begin
      exp_q.push_back(0);
      pulse(4'b0001);
      wait_req("sat");
      do_ack();
      step(2);
    end
    check_count("sat_count");
`endif

    // RST in the middle of a handshake
    exp_q.push_back(1);
    pulse(4'b0010);
    wait_req("rst_mid");
    RST = 1'b1;
    #1;
    check("rst_mid_req", 32'(irq_req), 32'h0);
    check("rst_mid_pend", 32'(irq_pending), 32'h0);
    check("rst_mid_count", 32'(irq_count), 32'h0);
    exp_count = 16'h0000;
    step(2);
    RST = 1'b0;
    step(6);
    check("rst_post_req", 32'(irq_req), 32'h0);
    check("rst_post_pend", 32'(irq_pending), 32'h0);
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
